// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: multi-flop synchronizer for a Gray-coded pointer crossing
// into the clk domain. It produces the synchronized Gray value, its registered
// binary form, and a change pulse with the forward distance moved.
// Optional multibit checker: define GRAY_PTR_SYNC_CHECK_EN to build it.
module gray_ptr_sync #(
  parameter int unsigned ADDR_LEN = 5,
  parameter int unsigned STAGES   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_LEN:0] in_gray,
  input  logic              err_clr,
  output logic [ADDR_LEN:0] out_gray,
  output logic [ADDR_LEN:0] out_bin,
  output logic              changed,
  output logic [ADDR_LEN:0] delta,
  output logic              err_multibit
);

  localparam int unsigned W = ADDR_LEN + 1;

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("gray_ptr_sync: STAGES must be in 2..4");
  end

  logic [W-1:0] r_sync [STAGES];
  logic [W-1:0] r_bin;
  logic [W-1:0] r_delta;
  logic         r_changed;
  logic [W-1:0] w_out_gray;
  logic [W-1:0] w_bin;
  logic         w_changed;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= in_gray;
      for (int unsigned k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_out_gray = r_sync[STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_bin = '0;
    for (int unsigned i = 0; i < W; i++) w_bin[i] = ^(w_out_gray >> i);
  end

  assign w_changed = (w_bin != r_bin);

  // Register binary value, change pulse and forward distance together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bin     <= '0;
      r_changed <= 1'b0;
      r_delta   <= '0;
    end else begin
      r_bin     <= w_bin;
      r_changed <= w_changed;
      r_delta   <= w_changed ? (w_bin - r_bin) : '0;
    end
  end

  assign out_gray = w_out_gray;
  assign out_bin  = r_bin;
  assign changed  = r_changed;
  assign delta    = r_delta;

`ifdef GRAY_PTR_SYNC_CHECK_EN
  logic         r_err;
  logic [W-1:0] w_prev_gray;
  logic [W-1:0] w_diff;
  logic         w_multi;

  // Previous out_gray is recovered from r_bin, so the checker needs no
  // extra history flop; this fires on the edge after out_gray moves.
  always_comb begin
    w_prev_gray = r_bin ^ (r_bin >> 1);
    w_diff      = w_prev_gray ^ w_out_gray;
    w_multi     = |(w_diff & (w_diff - W'(1)));
  end

  // Sticky multibit flag; a new event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        r_err <= 1'b0;
    else if (w_multi) r_err <= 1'b1;
    else if (err_clr) r_err <= 1'b0;
  end

  assign err_multibit = r_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err_multibit     = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed self-checking bench for gray_ptr_sync: a STAGES=2 instance for
// latency, multibit, clear and reset cases, and a STAGES=3 instance for a
// full Gray count with wrap.
module tb_gray_ptr_sync;

`ifdef GRAY_PTR_SYNC_CHECK_EN
  localparam logic CHK_ON = 1'b1;
`else
  localparam logic CHK_ON = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic       err_clr;
  logic [5:0] in_gray2, og2, ob2, dl2;
  logic       ch2, er2;
  logic [5:0] in_gray3, og3, ob3, dl3;
  logic       ch3, er3;

  int n_cmp = 0;
  int n_mis = 0;

  gray_ptr_sync #(.ADDR_LEN(5), .STAGES(2)) dut2 (
    .clk(clk), .rstn(rstn), .in_gray(in_gray2), .err_clr(err_clr),
    .out_gray(og2), .out_bin(ob2), .changed(ch2), .delta(dl2),
    .err_multibit(er2)
  );

  gray_ptr_sync #(.ADDR_LEN(5), .STAGES(3)) dut3 (
    .clk(clk), .rstn(rstn), .in_gray(in_gray3), .err_clr(err_clr),
    .out_gray(og3), .out_bin(ob3), .changed(ch3), .delta(dl3),
    .err_multibit(er3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] b;
    logic [5:0] g;
    int         npulse;

    rstn = 1'b1; err_clr = 1'b0; in_gray2 = '0; in_gray3 = '0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_og2", og2, 0);
    chk("rst_ob2", ob2, 0);
    chk("rst_ch2", ch2, 0);
    chk("rst_dl2", dl2, 0);
    chk("rst_er2", er2, 0);
    chk("rst_ob3", ob3, 0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    chk("first_edge_ch2", ch2, 0);
    chk("first_edge_og2", og2, 0);

    // single-bit step 0 -> 1
    in_gray2 = 6'b000001;
    tick(); chk("s1_e1_og", og2, 0);
    tick(); chk("s1_e2_og", og2, 1); chk("s1_e2_ob", ob2, 0); chk("s1_e2_ch", ch2, 0);
    tick(); chk("s1_e3_ob", ob2, 1); chk("s1_e3_ch", ch2, 1); chk("s1_e3_dl", dl2, 1);
    chk("s1_e3_er", er2, 0);
    tick(); chk("s1_e4_ch", ch2, 0); chk("s1_e4_dl", dl2, 0);
    repeat (6) begin
      tick(); chk("hold_ch", ch2, 0);
    end
    chk("hold_ob", ob2, 1);

    // backward step 1 -> 0 gives modular distance 63
    in_gray2 = 6'b000000;
    repeat (3) tick();
    chk("back_ob", ob2, 0); chk("back_ch", ch2, 1); chk("back_dl", dl2, 63);
    tick();

    // two-bit jump 0 -> 000011 (binary 2)
    in_gray2 = 6'b000011;
    repeat (2) tick();
    chk("mb_og", og2, 3); chk("mb_er_early", er2, 0);
    tick();
    chk("mb_ob", ob2, 2); chk("mb_ch", ch2, 1); chk("mb_dl", dl2, 2); chk("mb_er", er2, CHK_ON);
    tick();
    chk("mb_er_sticky", er2, CHK_ON); chk("mb_ch_off", ch2, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_er", er2, 0);
    tick(); chk("clr_er_hold", er2, 0);

    // two-bit jump 000011 -> 0 with clear on the same edge as the event
    in_gray2 = 6'b000000;
    repeat (2) tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("coin_er", er2, CHK_ON); chk("coin_ob", ob2, 0); chk("coin_ch", ch2, 1);
    chk("coin_dl", dl2, 62);
    tick(); chk("coin_er_hold", er2, CHK_ON);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("coin_clr", er2, 0);

    // reset while 000101 is mid-chain
    in_gray2 = 6'b000001;
    repeat (4) tick();
    chk("pre_rst_ob", ob2, 1);
    in_gray2 = 6'b000101;
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_og", og2, 0); chk("mid_rst_ob", ob2, 0); chk("mid_rst_ch", ch2, 0);
    chk("mid_rst_dl", dl2, 0); chk("mid_rst_er", er2, 0);
    tick(); chk("in_rst_og", og2, 0);
    rstn = 1'b1;
    tick(); chk("rel_e1_og", og2, 0); chk("rel_e1_ch", ch2, 0);
    tick(); chk("rel_e2_og", og2, 5); chk("rel_e2_ob", ob2, 0); chk("rel_e2_ch", ch2, 0);
    tick(); chk("rel_e3_ob", ob2, 6); chk("rel_e3_ch", ch2, 1); chk("rel_e3_dl", dl2, 6);
    tick(); chk("rel_e4_ch", ch2, 0);

    // STAGES=3: full Gray count with wrap, one step per 4 clocks
    npulse = 0;
    for (int i = 1; i <= 64; i++) begin
      b = 6'(i);
      g = b ^ (b >> 1);
      in_gray3 = g;
      for (int t = 1; t <= 4; t++) begin
        tick();
        if (ch3) npulse++;
        if (t == 3) begin
          chk("cnt_og3", og3, g);
          chk("cnt_ch3_early", ch3, 0);
        end
        if (t == 4) begin
          chk("cnt_ch3", ch3, 1);
          chk("cnt_dl3", dl3, 1);
          chk("cnt_ob3", ob3, b);
        end
      end
    end
    chk("cnt_pulses", npulse, 64);
    chk("cnt_er3", er3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
